tdm_comm_link: RTL
==================

Name: tdm_comm_link

Overview:
Parametrised time-division-multiplexed serial link, successor to the single-bit mux/demux communication system. TX scans NUM_CH input channels and serialises one framed word per enabled channel onto a one-bit line, carrying channel ID, even parity and a stop bit. RX deframes the line, checks parity and framing, and routes each word to its per-channel output register with a valid pulse. TX and RX are both in one block; the line is exposed as ser_out/ser_in so the bench can loop it back or corrupt it.

Parameters:
- NUM_CH, 4: channel count (>=2).
- DATA_W, 4: bits per channel word (>=1).
- CH_W: localparam, $clog2(NUM_CH); channel ID field width.
- FRAME_LEN: localparam, 1+CH_W+DATA_W+2; bits per frame (9 at defaults).

Ports:
- clk  input  1  sole clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request one TDM sweep; sampled only when busy=0.
- ch_en  input  NUM_CH  channel enable mask, snapshotted at accepted start.
- ch_data  input  NUM_CH*DATA_W  flattened words, ch k at [k*DATA_W +: DATA_W], snapshotted at accepted start.
- busy  output  1  TX sweep in progress.
- tx_done  output  1  one-cycle pulse at sweep end.
- ser_out  output  1  registered serial line; idle=1.
- ser_in  input  1  serial line into RX.
- rx_data  output  NUM_CH*DATA_W  last good word per channel, same packing as ch_data.
- rx_valid  output  NUM_CH  one-cycle pulse on the bit of the channel just written.
- parity_err  output  1  one-cycle pulse; bad parity.
- frame_err  output  1  one-cycle pulse; stop bit 0 or channel ID >= NUM_CH.

Behaviour:
- Reset (async, rst_n=0): ser_out=1, busy=0, tx_done=0, rx_data=0, rx_valid=0, parity_err=0, frame_err=0, TX and RX FSMs in IDLE. Mid-frame reset aborts with no partial write.
- Frame, one bit per clk, MSB first: start(0), ch ID[CH_W], data[DATA_W], parity (XOR of data, even), stop(1).
- TX FSM: IDLE -> SEND -> (SEND for next enabled channel | IDLE).
- Accept: start=1 and busy=0 at edge E0 snapshots ch_en/ch_data. Start bit is on ser_out after E0, and busy=1 from E0.
- Start while busy=1 is ignored.
- Channels go in ascending index. Disabled channels are skipped with zero idle cycles. Frames are back-to-back: the stop bit is followed directly by the next start bit.
- With n enabled channels, the final stop bit ends at edge E0+n*FRAME_LEN. At that edge busy->0, tx_done=1 for one cycle, and ser_out=1.
- ch_en=0 at accept: no frames, busy stays 0, tx_done pulses after E0+1.
- RX FSM: IDLE (hunt ser_in=0) -> HDR(CH_W) -> DATA(DATA_W) -> PAR -> STOP -> IDLE. WAIT_HI is entered after a frame_err.
- RX samples ser_in every edge; the start bit is detected in the same edge it is sampled.
- On the STOP edge, if stop=1, parity is good and ID<NUM_CH: write rx_data[ID], and rx_valid[ID]=1 for the next cycle.
- Bad parity with stop=1: parity_err pulse, no write, return to IDLE.
- stop=0: frame_err pulse, no write, go to WAIT_HI until ser_in=1, then IDLE. Invalid ID has the same outcome, and parity_err is not raised when frame_err is.
- Loopback latency: from accept edge E0, the first rx_valid is high after edge E0+FRAME_LEN. Frame j (0-based) completes at E0+(j+1)*FRAME_LEN.
- rx_data holds between writes. RX runs independently of busy.

Decomposition:
- Package tdm_pkg:
  - TX state encoding (IDLE/SEND) and RX state encoding (IDLE/HDR/DATA/PAR/STOP/WAIT_HI).
  - Function frame_len(ch_w, data_w).
  - Constants LINE_IDLE=1, START_BIT=0, STOP_BIT=1.
- Sub-module tdm_rx holds the deframer, parity/frame checks and per-channel registers. The TX FSM, next-enabled-channel priority find and shift register stay in tdm_comm_link.

Test Plan:
- Loopback, defaults: ch_data ch0..ch3 = A,3,6,D, ch_en=1111, start at E0 -> rx_valid 0001@E0+9 (data A), 0010@+18 (3), 0100@+27 (6), 1000@+36 (D). tx_done pulses @+36; no errors.
- Sparse mask ch_en=1010, same data -> only ch1=3@+9 and ch3=D@+18. tx_done @+18; rx_data ch0/ch2 stay 0.
- Parity inject: invert ser_in on ch1 data MSB during loopback -> parity_err pulse @+18, no rx_valid[1], rx_data ch1 unchanged. Ch2 still written 6@+27.
- Frame error: force ser_in=0 at ch0 stop bit, held 3 extra cycles -> frame_err @+9, RX stays in WAIT_HI until ser_in=1, then resumes on the next start bit.
- Start while busy ignored, and ch_en=0 -> tx_done @E0+1 with ser_out stuck at 1.
- Reset at E0+5 -> ser_out=1, busy=0, all pulses 0, rx_data=0. A fresh sweep after release completes normally.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM serial link: state encodings,
// frame geometry and line-level bit values.
package tdm_pkg;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE    = 3'd0,
    RX_HDR     = 3'd1,
    RX_DATA    = 3'd2,
    RX_PAR     = 3'd3,
    RX_STOP    = 3'd4,
    RX_WAIT_HI = 3'd5
  } rx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  function automatic int frame_len(input int ch_w, input int data_w);
    return 1 + ch_w + data_w + 2;
  endfunction

  // Even parity over a zero-extended word (the zero padding does not change it).
  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/tdm_rx.sv
// Deframer for the TDM link: hunts the start bit, collects ID/data/parity,
// checks the stop bit and ID range, and updates per-channel output registers.
module tdm_rx
  import tdm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_ser,
  output logic [NUM_CH*DATA_W-1:0] o_rx_data,
  output logic [NUM_CH-1:0]        o_rx_valid,
  output logic                     o_parity_err,
  output logic                     o_frame_err
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int HW    = CH_W + DATA_W;
  localparam int CNT_W = $clog2(HW + 1);

  rx_state_t                r_state;
  logic [HW-1:0]            r_sh;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_par;
  logic [NUM_CH*DATA_W-1:0] r_data;
  logic [NUM_CH-1:0]        r_valid;
  logic                     r_perr;
  logic                     r_ferr;

  logic [CH_W-1:0]   w_id;
  logic [DATA_W-1:0] w_word;
  logic              w_id_bad;
  logic              w_par_bad;

  // ID and data sit together in one shift register, ID in the upper bits.
  assign w_id      = r_sh[HW-1 -: CH_W];
  assign w_word    = r_sh[DATA_W-1:0];
  assign w_id_bad  = ({1'b0, w_id} >= (CH_W+1)'(NUM_CH));
  assign w_par_bad = even_parity(32'(w_word)) ^ r_par;

  // Receive state machine; pulses default low and are raised for one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= RX_IDLE;
      r_sh    <= {HW{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
      r_par   <= 1'b0;
      r_data  <= {(NUM_CH*DATA_W){1'b0}};
      r_valid <= {NUM_CH{1'b0}};
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= {NUM_CH{1'b0}};
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (i_ser == START_BIT) begin
            r_state <= RX_HDR;
            r_cnt   <= {CNT_W{1'b0}};
          end else begin
            r_state <= RX_IDLE;
          end
        end
        RX_HDR: begin
          r_sh <= {r_sh[HW-2:0], i_ser};
          if (r_cnt == CNT_W'(CH_W - 1)) begin
            r_state <= RX_DATA;
            r_cnt   <= {CNT_W{1'b0}};
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RX_DATA: begin
          r_sh <= {r_sh[HW-2:0], i_ser};
          if (r_cnt == CNT_W'(DATA_W - 1)) begin
            r_state <= RX_PAR;
            r_cnt   <= {CNT_W{1'b0}};
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        RX_PAR: begin
          r_par   <= i_ser;
          r_state <= RX_STOP;
        end
        RX_STOP: begin
          // Framing faults take precedence so parity_err never accompanies frame_err.
          if ((i_ser != STOP_BIT) || w_id_bad) begin
            r_ferr  <= 1'b1;
            r_state <= RX_WAIT_HI;
          end else if (w_par_bad) begin
            r_perr  <= 1'b1;
            r_state <= RX_IDLE;
          end else begin
            r_data[w_id*DATA_W +: DATA_W] <= w_word;
            r_valid[w_id]                 <= 1'b1;
            r_state                       <= RX_IDLE;
          end
        end
        RX_WAIT_HI: begin
          if (i_ser == LINE_IDLE) begin
            r_state <= RX_IDLE;
          end else begin
            r_state <= RX_WAIT_HI;
          end
        end
        default: begin
          r_state <= RX_IDLE;
        end
      endcase
    end
  end

  assign o_rx_data    = r_data;
  assign o_rx_valid   = r_valid;
  assign o_parity_err = r_perr;
  assign o_frame_err  = r_ferr;

endmodule

// File: rtl/tdm_comm_link.sv
// TDM serial link top: sweeps enabled channels in ascending order, sending one
// framed word per channel back-to-back on ser_out; ser_in feeds the deframer.
module tdm_comm_link
  import tdm_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     busy,
  output logic                     tx_done,
  output logic                     ser_out,
  input  logic                     ser_in,
  output logic [NUM_CH*DATA_W-1:0] rx_data,
  output logic [NUM_CH-1:0]        rx_valid,
  output logic                     parity_err,
  output logic                     frame_err
);

  localparam int CH_W      = $clog2(NUM_CH);
  localparam int FRAME_LEN = frame_len(CH_W, DATA_W);
  localparam int SH_W      = FRAME_LEN - 1;
  localparam int CNT_W     = $clog2(FRAME_LEN);

  tx_state_t                r_state;
  logic [NUM_CH-1:0]        r_en;
  logic [NUM_CH*DATA_W-1:0] r_data;
  logic [CH_W-1:0]          r_cur;
  logic [SH_W-1:0]          r_shift;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_ser;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_empty_pend;

  logic              w_first_found;
  logic [CH_W-1:0]   w_first_idx;
  logic              w_next_found;
  logic [CH_W-1:0]   w_next_idx;
  logic [DATA_W-1:0] w_first_data;
  logic [DATA_W-1:0] w_next_data;

  // Everything after the start bit, MSB first: ID, data, parity, stop.
  function automatic logic [SH_W-1:0] build_frame(input logic [CH_W-1:0] id,
                                                  input logic [DATA_W-1:0] d);
    return {id, d, even_parity(32'(d)), STOP_BIT};
  endfunction

  // Priority find: lowest enabled channel overall, and lowest above the current one.
  always_comb begin
    w_first_found = 1'b0;
    w_first_idx   = {CH_W{1'b0}};
    w_next_found  = 1'b0;
    w_next_idx    = {CH_W{1'b0}};
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      w_first_found = w_first_found | ch_en[k];
      w_first_idx   = ch_en[k] ? CH_W'(k) : w_first_idx;
      w_next_found  = w_next_found | (r_en[k] && (k > int'(r_cur)));
      w_next_idx    = (r_en[k] && (k > int'(r_cur))) ? CH_W'(k) : w_next_idx;
    end
  end

  assign w_first_data = ch_data[w_first_idx*DATA_W +: DATA_W];
  assign w_next_data  = r_data[w_next_idx*DATA_W +: DATA_W];

  // Transmit state machine with registered line, busy and done outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= TX_IDLE;
      r_en         <= {NUM_CH{1'b0}};
      r_data       <= {(NUM_CH*DATA_W){1'b0}};
      r_cur        <= {CH_W{1'b0}};
      r_shift      <= {SH_W{1'b0}};
      r_cnt        <= {CNT_W{1'b0}};
      r_ser        <= LINE_IDLE;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_empty_pend <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_empty_pend <= 1'b0;
      case (r_state)
        TX_IDLE: begin
          r_ser  <= LINE_IDLE;
          r_busy <= 1'b0;
          // An empty sweep reports completion one cycle after acceptance.
          if (r_empty_pend) begin
            r_done <= 1'b1;
          end else begin
            r_done <= 1'b0;
          end
          if (start) begin
            r_en   <= ch_en;
            r_data <= ch_data;
            if (w_first_found) begin
              r_state <= TX_SEND;
              r_busy  <= 1'b1;
              r_ser   <= START_BIT;
              r_shift <= build_frame(w_first_idx, w_first_data);
              r_cur   <= w_first_idx;
              r_cnt   <= {CNT_W{1'b0}};
            end else begin
              r_empty_pend <= 1'b1;
            end
          end else begin
            r_state <= TX_IDLE;
          end
        end
        TX_SEND: begin
          if (r_cnt != CNT_W'(FRAME_LEN - 1)) begin
            r_ser   <= r_shift[SH_W-1];
            r_shift <= {r_shift[SH_W-2:0], 1'b0};
            r_cnt   <= r_cnt + CNT_W'(1);
          end else if (w_next_found) begin
            r_ser   <= START_BIT;
            r_shift <= build_frame(w_next_idx, w_next_data);
            r_cur   <= w_next_idx;
            r_cnt   <= {CNT_W{1'b0}};
          end else begin
            r_state <= TX_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_ser   <= LINE_IDLE;
          end
        end
        default: begin
          r_state <= TX_IDLE;
          r_busy  <= 1'b0;
          r_ser   <= LINE_IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign tx_done = r_done;
  assign ser_out = r_ser;

  tdm_rx #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W)
  ) u_rx (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_ser        (ser_in),
    .o_rx_data    (rx_data),
    .o_rx_valid   (rx_valid),
    .o_parity_err (parity_err),
    .o_frame_err  (frame_err)
  );

endmodule
